// File: rtl/i2c_passthru_bit_rx_if.sv
// i2c_passthru_bit_rx_if
//   Bundles the per-bit receive sequencer's channel lines, controller
//   handshake and results.
//   master modport: rx/tx controller side (drives lines, start, select).
//   slave  modport: the i2c_passthru_bit_rx block itself.
//   Signals:
//     i_cha_scl/i_cha_sda   master-side channel lines (synchronized)
//     i_chb_scl/i_chb_sda   slave-side channel lines (synchronized)
//     i_start               one-cycle pulse, begin receiving one bit
//     i_tx_to_mst           channel select captured with i_start (0=A, 1=B)
//     o_rx_done             high when idle or bit complete
//     o_rx_sda_init_valid   o_rx_sda_init holds this bit's sampled SDA
//     o_rx_sda_init         SDA sampled at filtered SCL rise
//     o_rx_sda              live SDA of selected channel, one cycle late
//     o_sda_cond            sticky START/STOP seen during this bit
//     o_timeout             one-cycle pulse, bit aborted by timeout
interface i2c_passthru_bit_rx_if;
  logic i_cha_scl;
  logic i_cha_sda;
  logic i_chb_scl;
  logic i_chb_sda;
  logic i_start;
  logic i_tx_to_mst;
  logic o_rx_done;
  logic o_rx_sda_init_valid;
  logic o_rx_sda_init;
  logic o_rx_sda;
  logic o_sda_cond;
  logic o_timeout;

  modport master (
    output i_cha_scl, i_cha_sda, i_chb_scl, i_chb_sda, i_start, i_tx_to_mst,
    input  o_rx_done, o_rx_sda_init_valid, o_rx_sda_init, o_rx_sda,
           o_sda_cond, o_timeout
  );

  modport slave (
    input  i_cha_scl, i_cha_sda, i_chb_scl, i_chb_sda, i_start, i_tx_to_mst,
    output o_rx_done, o_rx_sda_init_valid, o_rx_sda_init, o_rx_sda,
           o_sda_cond, o_timeout
  );
endinterface

// File: rtl/i2c_passthru_bit_rx.sv
// i2c_passthru_bit_rx
//   Per-bit receive sequencer for the I2C pass-through. On i_start it
//   latches which channel is receiving, waits for a filtered SCL high,
//   samples SDA, mirrors SDA live for the transmit side, and reports bit
//   completion on the filtered SCL fall.
//   Parameters:
//     FILT_LEN   consecutive raw SCL samples needed to flip filtered SCL (1..15)
//     TIMEOUT_W  stuck-bus timeout counter width (timeout build only)
//   Ports:
//     i_clk      clock, rising edge
//     i_rstn     asynchronous active-low reset
//     bus        i2c_passthru_bit_rx_if.slave (lines, handshake, results)
//   Build option:
//     I2C_PASSTHRU_RX_TIMEOUT_EN  adds the stuck-bus timeout; otherwise
//     o_timeout is tied low and a stuck SCL holds the bit open.
module i2c_passthru_bit_rx #(
  parameter int unsigned FILT_LEN  = 3,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  i2c_passthru_bit_rx_if.slave  bus
);

  if (FILT_LEN < 1 || FILT_LEN > 15 || TIMEOUT_W < 1) begin : g_bad_params
    $error("i2c_passthru_bit_rx: illegal FILT_LEN or TIMEOUT_W");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HI,
    HIGH
  } state_e;

  state_e     state_q, state_d;
  logic       sel_q;
  logic       rx_scl;
  logic       rx_sda;
  logic       filt_q;
  logic [3:0] fcnt_q;
  logic       done_q, done_d;
  logic       valid_q, valid_d;
  logic       init_q, init_d;
  logic       cond_q, cond_d;
  logic       rxsda_q;
  logic       timed_out;

  assign rx_scl = sel_q ? bus.i_chb_scl : bus.i_cha_scl;
  assign rx_sda = sel_q ? bus.i_chb_sda : bus.i_cha_sda;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sel_q <= 1'b0;
    end else if (bus.i_start) begin
      sel_q <= bus.i_tx_to_mst;
    end
  end

  // Glitch filter: filtered SCL flips only after FILT_LEN consecutive
  // differing raw samples. A start restarts the count but keeps the level,
  // so a bit following an already-high SCL samples on the next edge.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (bus.i_start || (rx_scl == filt_q)) begin
      fcnt_q <= '0;
    end else if (fcnt_q == 4'(FILT_LEN - 1)) begin
      filt_q <= ~filt_q;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rxsda_q <= 1'b1;
    end else begin
      rxsda_q <= (state_q == IDLE) ? 1'b1 : rx_sda;
    end
  end

`ifdef I2C_PASSTHRU_RX_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tcnt_q;
  logic                 to_q;

  // Counter saturates at all-ones; a bit still open at that point is dropped.
  assign timed_out = (state_q != IDLE) && (&tcnt_q);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tcnt_q <= '0;
      to_q   <= 1'b0;
    end else begin
      to_q <= timed_out && !bus.i_start;
      if (bus.i_start) begin
        tcnt_q <= '0;
      end else if ((state_q != IDLE) && !(&tcnt_q)) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end

  assign bus.o_timeout = to_q;
`else
  assign timed_out     = 1'b0;
  assign bus.o_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    valid_d = valid_q;
    init_d  = init_q;
    cond_d  = cond_q;
    if (bus.i_start) begin
      state_d = WAIT_HI;
      done_d  = 1'b0;
      valid_d = 1'b0;
      cond_d  = 1'b0;
    end else if (timed_out) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        WAIT_HI: begin
          if (filt_q) begin
            state_d = HIGH;
            init_d  = rx_sda;
            valid_d = 1'b1;
          end
        end
        HIGH: begin
          if (!filt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (rx_sda != init_q) begin
            cond_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      done_q  <= 1'b1;
      valid_q <= 1'b0;
      init_q  <= 1'b1;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      init_q  <= init_d;
      cond_q  <= cond_d;
    end
  end

  assign bus.o_rx_done           = done_q;
  assign bus.o_rx_sda_init_valid = valid_q;
  assign bus.o_rx_sda_init       = init_q;
  assign bus.o_rx_sda            = rxsda_q;
  assign bus.o_sda_cond          = cond_q;

endmodule

// File: tb/tb_i2c_passthru_bit_rx.sv
// tb_i2c_passthru_bit_rx
//   Self-checking bench for i2c_passthru_bit_rx: directed scenarios plus
//   randomized bits on both channels, compared every cycle against a
//   behavioural model that tracks the bit as "active / sampled" flags and
//   the SCL filter as a queue of recent disagreeing samples.
//   Honours I2C_PASSTHRU_RX_TIMEOUT_EN (shorter phases keep directed bits
//   inside the 4-bit timeout window).
module tb_i2c_passthru_bit_rx;
  localparam int unsigned FILT_LEN = 3;
  localparam int unsigned TW       = 4;
`ifdef I2C_PASSTHRU_RX_TIMEOUT_EN
  localparam int unsigned LO_N = 4;
  localparam int unsigned HI_N = 5;
  localparam int unsigned LAG_N = 4;
`else
  localparam int unsigned LO_N = 20;
  localparam int unsigned HI_N = 20;
  localparam int unsigned LAG_N = 8;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  i2c_passthru_bit_rx_if bus ();

  i2c_passthru_bit_rx #(
    .FILT_LEN  (FILT_LEN),
    .TIMEOUT_W (TW)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_sel, m_filt, m_active, m_done, m_valid, m_init;
  bit          m_rxsda, m_cond, m_to;
  bit          hist[$];
  int unsigned m_age;

  function automatic void model_reset();
    m_sel = 0; m_filt = 1; hist.delete(); m_active = 0; m_done = 1;
    m_valid = 0; m_init = 1; m_rxsda = 1; m_cond = 0; m_to = 0; m_age = 0;
  endfunction

  // One bit in progress: waiting for SCL high until sampled, then watching
  // for the SCL fall and any SDA change while high.
  function automatic void bit_progress(input bit f, input bit sda);
    if (!m_valid) begin
      if (f) begin
        m_valid = 1;
        m_init  = sda;
      end
    end else if (!f) begin
      m_active = 0;
      m_done   = 1;
    end else if (sda != m_init) begin
      m_cond = 1;
    end
  endfunction

  function automatic void model_edge();
    bit raw_scl, raw_sda, f;
    f       = m_filt;
    raw_scl = m_sel ? bus.i_chb_scl : bus.i_cha_scl;
    raw_sda = m_sel ? bus.i_chb_sda : bus.i_cha_sda;
    m_rxsda = m_active ? raw_sda : 1'b1;
    if (bus.i_start || raw_scl == m_filt) begin
      hist.delete();
    end else begin
      hist.push_back(raw_scl);
      if (hist.size() == FILT_LEN) begin
        m_filt = !m_filt;
        hist.delete();
      end
    end
    m_to = 0;
    if (bus.i_start) begin
      m_sel = bus.i_tx_to_mst; m_active = 1; m_done = 0;
      m_valid = 0; m_cond = 0; m_age = 0;
    end else if (m_active) begin
`ifdef I2C_PASSTHRU_RX_TIMEOUT_EN
      if (m_age == (2 ** TW) - 1) begin
        m_active = 0;
        m_done   = 1;
        m_to     = 1;
      end else begin
        m_age++;
        bit_progress(f, raw_sda);
      end
`else
      bit_progress(f, raw_sda);
`endif
    end
  endfunction

  task automatic compare_all();
    check("rx_done",  bus.o_rx_done,           m_done);
    check("valid",    bus.o_rx_sda_init_valid, m_valid);
    check("init",     bus.o_rx_sda_init,       m_init);
    check("rx_sda",   bus.o_rx_sda,            m_rxsda);
    check("sda_cond", bus.o_sda_cond,          m_cond);
    check("timeout",  bus.o_timeout,           m_to);
  endtask

  // ---------------- stimulus helpers ----------------
  bit noise_en = 0;
  bit noise_ch = 0;

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (noise_en) begin
      if (noise_ch) begin
        bus.i_chb_scl = 1'($urandom_range(0, 1));
        bus.i_chb_sda = 1'($urandom_range(0, 1));
      end else begin
        bus.i_cha_scl = 1'($urandom_range(0, 1));
        bus.i_cha_sda = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic set_ch(input bit ch, input bit scl, input bit sda);
    if (ch) begin
      bus.i_chb_scl = scl; bus.i_chb_sda = sda;
    end else begin
      bus.i_cha_scl = scl; bus.i_cha_sda = sda;
    end
  endtask

  task automatic start_bit(input bit ch);
    bus.i_tx_to_mst = ch;
    bus.i_start     = 1'b1;
    noise_ch        = !ch;
    tick();
    bus.i_start     = 1'b0;
  endtask

  task automatic rand_bit();
    bit ch, sda;
    ch  = 1'($urandom_range(0, 1));
    sda = 1'($urandom_range(0, 1));
    noise_en = 1;
    start_bit(ch);
    set_ch(ch, 0, sda);
    ticks($urandom_range(0, 6));
    if ($urandom_range(0, 2) == 0) begin
      set_ch(ch, 1, sda);
      ticks($urandom_range(1, FILT_LEN - 1));
      set_ch(ch, 0, sda);
      ticks(2);
    end
    set_ch(ch, 1, sda);
    ticks($urandom_range(3, 9));
    if ($urandom_range(0, 3) == 0) begin
      set_ch(ch, 1, !sda);
      ticks($urandom_range(1, 3));
    end
    set_ch(ch, 0, 1'($urandom_range(0, 1)));
    ticks($urandom_range(0, 5));
  endtask

  // ---------------- main sequence ----------------
  bit prev;

  initial begin
    bus.i_cha_scl = 1; bus.i_cha_sda = 1; bus.i_chb_scl = 1; bus.i_chb_sda = 1;
    bus.i_start = 0; bus.i_tx_to_mst = 0;
    rstn = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    check("rst_done",  bus.o_rx_done, 1'b1);
    check("rst_valid", bus.o_rx_sda_init_valid, 1'b0);
    @(negedge clk);
    rstn = 1;
    ticks(2);

    // Channel A bit, B noise ignored
    set_ch(0, 0, 0);
    ticks(FILT_LEN + 1);
    noise_en = 1;
    start_bit(0);
    check("a_done_low", bus.o_rx_done, 1'b0);
    ticks(LO_N);
    set_ch(0, 1, 0);
    ticks(FILT_LEN);
    check("a_valid_early", bus.o_rx_sda_init_valid, 1'b0);
    tick();
    check("a_valid_m3", bus.o_rx_sda_init_valid, 1'b1);
    check("a_init0", bus.o_rx_sda_init, 1'b0);
    ticks(HI_N - FILT_LEN - 1);
    set_ch(0, 0, 0);
    ticks(FILT_LEN);
    check("a_done_early", bus.o_rx_done, 1'b0);
    tick();
    check("a_done_l3", bus.o_rx_done, 1'b1);
    ticks(3);

    // Channel B bit with SDA=1, o_rx_sda lags B SDA by one cycle
    noise_en = 1;
    set_ch(1, 0, 1);
    start_bit(1);
    tick();
    for (int unsigned i = 0; i < LAG_N; i++) begin
      prev = bus.i_chb_sda;
      tick();
      check("b_rx_sda_lag", bus.o_rx_sda, prev);
      bus.i_chb_sda = 1'($urandom_range(0, 1));
    end
    bus.i_chb_sda = 1;
    set_ch(1, 1, 1);
    ticks(FILT_LEN + 1);
    check("b_valid", bus.o_rx_sda_init_valid, 1'b1);
    check("b_init1", bus.o_rx_sda_init, 1'b1);
    set_ch(1, 0, 1);
    ticks(FILT_LEN + 2);
    noise_en = 0;

    // Short glitch during WAIT_HI, then a clean high
    set_ch(0, 0, 1);
    start_bit(0);
    ticks(2);
    set_ch(0, 1, 1);
    ticks(FILT_LEN - 1);
    set_ch(0, 0, 1);
    ticks(FILT_LEN + 1);
    check("glitch_valid", bus.o_rx_sda_init_valid, 1'b0);
    check("glitch_done",  bus.o_rx_done, 1'b0);
    set_ch(0, 1, 1);
    ticks(FILT_LEN + 1);
    check("post_glitch_valid", bus.o_rx_sda_init_valid, 1'b1);

    // SDA falls while SCL high: START/STOP condition is sticky
    set_ch(0, 1, 0);
    ticks(2);
    check("cond_set", bus.o_sda_cond, 1'b1);
    set_ch(0, 0, 0);
    ticks(FILT_LEN + 1);
    check("cond_done", bus.o_rx_done, 1'b1);
    check("cond_held", bus.o_sda_cond, 1'b1);
    ticks(2);
    start_bit(0);
    check("cond_clr", bus.o_sda_cond, 1'b0);
    ticks(3);

`ifdef I2C_PASSTHRU_RX_TIMEOUT_EN
    // SCL stuck low: bit must abort with a timeout pulse
    begin
      bit seen;
      seen = 0;
      set_ch(0, 0, 1);
      start_bit(0);
      for (int unsigned i = 0; i < 24 && !seen; i++) begin
        tick();
        if (bus.o_timeout) seen = 1;
      end
      check("to_seen", seen, 1'b1);
      check("to_done", bus.o_rx_done, 1'b1);
      check("to_valid", bus.o_rx_sda_init_valid, 1'b0);
      tick();
      check("to_pulse_end", bus.o_timeout, 1'b0);
    end
`endif

    // Asynchronous reset in the middle of a HIGH phase
    set_ch(0, 0, 0);
    ticks(FILT_LEN + 1);
    start_bit(0);
    set_ch(0, 1, 0);
    ticks(FILT_LEN + 2);
    #2;
    rstn = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rstn = 1;
    set_ch(0, 1, 1);
    set_ch(1, 1, 1);
    ticks(FILT_LEN + 1);

    // Randomized bits on both channels
    for (int unsigned n = 0; n < 80; n++) rand_bit();
    noise_en = 0;
    ticks(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
